multi_channel_tick_divider: RTL

Parametrised successor to the single-channel PLL-clocked tick divider. It generates NUM_CH independent tick streams from one clock, typically the 120 MHz PLL output. Each channel has a runtime-programmable divisor, a per-channel enable and a 50 %-duty square-wave output. Divisor updates are double-buffered and glitch-free, and a global sync clear phase-aligns all channels. It feeds LED/UART/scan-rate logic that needs several rates from one PLL.

---
 rtl/multi_channel_tick_divider.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/multi_channel_tick_divider.sv
// multi_channel_tick_divider
//   NUM_CH independent tick/square-wave generators driven from one clock.
//   Each channel has a double-buffered, runtime-programmable divisor
//   (period = D+1 cycles), a level enable, and a 50 %-duty square wave.
//   A global sync_clr realigns every channel and applies pending divisors.
//
// Ports
//   ref_clk      in   single clock, rising edge
//   rst          in   synchronous, active-low reset
//   ch_en        in   [NUM_CH]     per-channel count enable (level)
//   sync_clr     in   realign all channels (active high, synchronous)
//   cfg_we       in   one-cycle divisor write strobe
//   cfg_ch       in   [CH_W]       target channel (>= NUM_CH is ignored)
//   cfg_div      in   [CNT_WIDTH]  new divisor D
//   tick         out  [NUM_CH]     one-cycle pulse at each terminal count
//   sq           out  [NUM_CH]     square wave, toggles at each terminal count
//   cfg_pending  out  [NUM_CH]     shadow divisor waiting for its reload point

// One channel: counter, active/shadow divisor pair and output flops.
module mctd_lane #(
    parameter int CNT_WIDTH   = 27,
    parameter int DEFAULT_DIV = 120000000 - 1
) (
    input  logic                 ref_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic                 cfg_sel,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic                 tick,
    output logic                 sq,
    output logic                 pending
);
    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_act_q, div_act_d;
    logic [CNT_WIDTH-1:0] div_shd_q, div_shd_d;
    logic                 pend_q, pend_d;
    logic                 tick_q, tick_d;
    logic                 sq_q, sq_d;

    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        pend_d    = pend_q;
        tick_d    = 1'b0;
        sq_d      = sq_q;
        if (sync_clr) begin
            // Realign: restart the period and adopt any waiting divisor now.
            // A write landing in this same cycle is deliberately dropped.
            cnt_d = '0;
            sq_d  = 1'b0;
            if (pend_q) begin
                div_act_d = div_shd_q;
                pend_d    = 1'b0;
            end
        end else begin
            if (en) begin
                if (cnt_q == div_act_q) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    sq_d   = ~sq_q;
                    // Reload uses the shadow as it stood before this edge.
                    if (pend_q) begin
                        div_act_d = div_shd_q;
                        pend_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            // Placed after the reload so a write on the terminal edge stays
            // pending for the following period.
            if (cfg_sel) begin
                div_shd_d = cfg_div;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            div_act_q <= DEF_DIV;
            div_shd_q <= DEF_DIV;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            sq_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            sq_q      <= sq_d;
        end
    end

    assign tick    = tick_q;
    assign sq      = sq_q;
    assign pending = pend_q;
endmodule

module multi_channel_tick_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 27,
    parameter int DEFAULT_DIV = 120000000 - 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 ref_clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync_clr,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    sq,
    output logic [NUM_CH-1:0]    cfg_pending
);
    logic [NUM_CH-1:0] cfg_sel;

    // Only indices 0..NUM_CH-1 are decoded, so out-of-range cfg_ch values
    // select nothing and the write is ignored.
    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_CH; i++)
            cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        mctd_lane #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_lane (
            .ref_clk  (ref_clk),
            .rst      (rst),
            .en       (ch_en[g]),
            .sync_clr (sync_clr),
            .cfg_sel  (cfg_sel[g]),
            .cfg_div  (cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pending  (cfg_pending[g])
        );
    end
endmodule
